// File: rtl/internal_framebuffer_arbiter_pkg.sv
// internal_framebuffer_arbiter_pkg: shared types and helpers for the framebuffer tile RAM arbiter.
// Contents: arbiter state enum, requester port indices, clog2 helper for counter widths.
package internal_framebuffer_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_e;

    localparam logic PORT_PIXEL  = 1'b0;
    localparam logic PORT_STREAM = 1'b1;

    // Minimum width of 1 so a counter never collapses to zero bits.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/internal_framebuffer_arbiter_if.sv
// internal_framebuffer_arbiter_if: requester/arbiter bundle for the tile RAM arbiter.
// Requester side drives req/lock/read per port; arbiter side returns grants,
// RAM wrapper enables, per-port read-valid strobes and busy.
interface internal_framebuffer_arbiter_if;

    logic req0;
    logic lock0;
    logic read0;
    logic req1;
    logic lock1;
    logic read1;
    logic grant0;
    logic grant1;
    logic enablePort0;
    logic enablePort1;
    logic readValid0;
    logic readValid1;
    logic busy;

    modport master (
        output req0, lock0, read0, req1, lock1, read1,
        input  grant0, grant1, enablePort0, enablePort1, readValid0, readValid1, busy
    );

    modport slave (
        input  req0, lock0, read0, req1, lock1, read1,
        output grant0, grant1, enablePort0, enablePort1, readValid0, readValid1, busy
    );

endinterface

// File: rtl/internal_framebuffer_arbiter_read_tag_pipe.sv
// read_tag_pipe: DEPTH-deep, 2-bit-wide shift register with synchronous clear.
// Ports: clk, reset (sync clear), tag_in[1:0] (one bit per port), tag_out[1:0] (tag_in delayed DEPTH cycles).
module read_tag_pipe #(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] tag_in,
    output logic [1:0] tag_out
);

    logic [1:0] pipe_q [DEPTH];
    logic [1:0] pipe_d [DEPTH];

    always_comb begin
        pipe_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) pipe_q[i] <= reset ? 2'b00 : pipe_d[i];
    end

    assign tag_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/internal_framebuffer_arbiter.sv
// internal_framebuffer_arbiter: time-multiplexes the tile RAM between the pixel pipeline (port 0)
// and the stream-out/clear unit (port 1).
// Ports: clk, reset (sync, active-high), bus (slave modport: req/lock/read in, grants,
// RAM enables, read-valid strobes and busy out).
// Optional: define INTERNAL_FB_ARB_LOCK_TIMEOUT_EN to bound a contested lock to LOCK_TIMEOUT cycles.
module internal_framebuffer_arbiter
    import internal_framebuffer_arbiter_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int MAX_BURST    = 16,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    internal_framebuffer_arbiter_if.slave bus
);

    localparam int BW = clog2(MAX_BURST);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST - 1);

    arb_state_e    state_q, state_d;
    logic          last_q, last_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          lock0_eff, lock1_eff;
    logic          hold0, hold1, entering;
    logic [1:0]    read_valid;

`ifdef INTERNAL_FB_ARB_LOCK_TIMEOUT_EN
    localparam int LW = clog2(LOCK_TIMEOUT);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_TIMEOUT - 1);
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic          own_locked;
    assign own_locked = (state_q == OWN0 && bus.lock0) || (state_q == OWN1 && bus.lock1);
    assign lock_cnt_d = entering ? '0
                      : (own_locked && lock_cnt_q != LOCK_MAX) ? lock_cnt_q + 1'b1
                      : lock_cnt_q;
    // A lock that has run its full term is ignored only while the other port is waiting.
    assign lock0_eff = bus.lock0 && !(lock_cnt_q == LOCK_MAX && bus.req1);
    assign lock1_eff = bus.lock1 && !(lock_cnt_q == LOCK_MAX && bus.req0);
    always_ff @(posedge clk) begin
        lock_cnt_q <= reset ? '0 : lock_cnt_d;
    end
`else
    assign lock0_eff = bus.lock0;
    assign lock1_eff = bus.lock1;
`endif

    always_comb begin
        hold0 = bus.req0 && (lock0_eff || !bus.req1 || burst_q != BURST_MAX);
        hold1 = bus.req1 && (lock1_eff || !bus.req0 || burst_q != BURST_MAX);
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = (bus.req0 && bus.req1) ? ((last_q == PORT_PIXEL) ? OWN1 : OWN0)
                             : bus.req0 ? OWN0 : bus.req1 ? OWN1 : IDLE;
            OWN0:    state_d = hold0 ? OWN0 : bus.req1 ? OWN1 : IDLE;
            OWN1:    state_d = hold1 ? OWN1 : bus.req0 ? OWN0 : IDLE;
            default: state_d = IDLE;
        endcase
        entering = (state_d != state_q) && (state_d != IDLE);
        last_d   = (state_d == OWN0) ? PORT_PIXEL : (state_d == OWN1) ? PORT_STREAM : last_q;
        burst_d  = entering ? '0
                 : (state_q != IDLE && burst_q != BURST_MAX) ? burst_q + 1'b1
                 : burst_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= PORT_STREAM;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

    read_tag_pipe #(.DEPTH(READ_LATENCY)) u_read_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  ({bus.read1 && bus.grant1, bus.read0 && bus.grant0}),
        .tag_out (read_valid)
    );

    assign bus.grant0      = (state_q == OWN0);
    assign bus.grant1      = (state_q == OWN1);
    assign bus.enablePort0 = bus.grant0;
    assign bus.enablePort1 = bus.grant1;
    assign bus.readValid0  = read_valid[0];
    assign bus.readValid1  = read_valid[1];
    assign bus.busy        = bus.grant0 || bus.grant1;

endmodule

// File: tb/tb_internal_framebuffer_arbiter.sv
// tb_internal_framebuffer_arbiter: directed scoreboard bench, MAX_BURST=4, READ_LATENCY=2.
module tb_internal_framebuffer_arbiter;

    typedef struct {
        string      name;
        logic [6:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    internal_framebuffer_arbiter_if bus();

    internal_framebuffer_arbiter #(
        .READ_LATENCY (2),
        .MAX_BURST    (4),
        .LOCK_TIMEOUT (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus. p0/p1 = {req, lock, read}; e = {grant0, grant1, readValid0, readValid1}
    // expected during this cycle. Enables mirror grants and busy is their OR.
    task automatic step(input string nm, input bit chk, input bit rs,
                        input bit [2:0] p0, input bit [2:0] p1, input bit [3:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        reset     = rs;
        bus.req0  = p0[2];
        bus.lock0 = p0[1];
        bus.read0 = p0[0];
        bus.req1  = p1[2];
        bus.lock1 = p1[1];
        bus.read1 = p1[0];
        if (chk) begin
            x.name = nm;
            x.v    = {e[3], e[2], e[3], e[2], e[1], e[0], e[3] | e[2]};
            exp_q.push_back(x);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            logic [6:0] act;
            x   = exp_q.pop_front();
            act = {bus.grant0, bus.grant1, bus.enablePort0, bus.enablePort1,
                   bus.readValid0, bus.readValid1, bus.busy};
            total++;
            if (act !== x.v) begin
                bad++;
                $display("FAIL %s got g0,g1,en0,en1,rv0,rv1,busy=%b want=%b", x.name, act, x.v);
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.req0 = 0; bus.lock0 = 0; bus.read0 = 0;
        bus.req1 = 0; bus.lock1 = 0; bus.read1 = 0;
        step("rst0", 0, 1, 3'b000, 3'b000, 4'b0000);
        step("rst",  1, 1, 3'b000, 3'b000, 4'b0000);
        // single requester: grant from cycle 2, held while alone
        step("a_idle", 1, 0, 3'b100, 3'b000, 4'b0000);
        repeat (5) step("a_own0", 1, 0, 3'b100, 3'b000, 4'b1000);
        step("a_rel",  1, 0, 3'b000, 3'b000, 4'b1000);
        step("a_idle2", 1, 0, 3'b000, 3'b000, 4'b0000);
        // continuous tie after reset: 4-cycle bursts alternate with no gap
        step("b_rst",  1, 1, 3'b000, 3'b000, 4'b0000);
        step("b_idle", 1, 0, 3'b100, 3'b100, 4'b0000);
        repeat (4) step("b_own0", 1, 0, 3'b100, 3'b100, 4'b1000);
        repeat (4) step("b_own1", 1, 0, 3'b100, 3'b100, 4'b0100);
        repeat (4) step("b_own0b", 1, 0, 3'b100, 3'b100, 4'b1000);
        step("b_sw",    1, 0, 3'b000, 3'b000, 4'b0100);
        step("b_idle2", 1, 0, 3'b000, 3'b000, 4'b0000);
        // port 1 lock holds 100 cycles against a pending port 0
        step("c_idle", 1, 0, 3'b000, 3'b110, 4'b0000);
        repeat (100) step("c_lock", 1, 0, 3'b100, 3'b110, 4'b0100);
        step("c_rel",   1, 0, 3'b100, 3'b000, 4'b0100);
        step("c_own0",  1, 0, 3'b000, 3'b000, 4'b1000);
        step("c_idle2", 1, 0, 3'b000, 3'b000, 4'b0000);
        // read tags across a back-to-back switch; ungranted read1 must not tag
        step("d_idle", 1, 0, 3'b100, 3'b000, 4'b0000);
        repeat (3) step("d_own0", 1, 0, 3'b100, 3'b100, 4'b1000);
        step("d_rd0",   1, 0, 3'b101, 3'b101, 4'b1000);
        step("d_rd1",   1, 0, 3'b100, 3'b101, 4'b0100);
        step("d_rv0",   1, 0, 3'b100, 3'b100, 4'b0110);
        step("d_rv1",   1, 0, 3'b100, 3'b100, 4'b0101);
        step("d_tail",  1, 0, 3'b000, 3'b000, 4'b0100);
        step("d_idle2", 1, 0, 3'b000, 3'b000, 4'b0000);
        // reset mid-burst discards the in-flight read; fresh request works afterwards
        step("e_idle",  1, 0, 3'b100, 3'b000, 4'b0000);
        step("e_rd",    1, 0, 3'b101, 3'b000, 4'b1000);
        step("e_rstin", 1, 1, 3'b100, 3'b000, 4'b1000);
        step("e_clr",   1, 0, 3'b000, 3'b000, 4'b0000);
        step("e_idle2", 1, 0, 3'b000, 3'b100, 4'b0000);
        step("e_own1",  1, 0, 3'b000, 3'b100, 4'b0100);
        step("e_rd1",   1, 0, 3'b000, 3'b101, 4'b0100);
        step("e_rel",   1, 0, 3'b000, 3'b000, 4'b0100);
        step("e_rv1",   1, 0, 3'b000, 3'b000, 4'b0001);
        step("e_idle3", 1, 0, 3'b000, 3'b000, 4'b0000);
        // lock0 beyond the burst limit, then req0 drops mid-lock; later tie goes to port 0
        step("f_idle",  1, 0, 3'b110, 3'b000, 4'b0000);
        repeat (5) step("f_lock", 1, 0, 3'b110, 3'b100, 4'b1000);
        step("f_drop",  1, 0, 3'b010, 3'b100, 4'b1000);
        step("f_own1",  1, 0, 3'b000, 3'b100, 4'b0100);
        step("f_rel",   1, 0, 3'b000, 3'b000, 4'b0100);
        step("f_tie",   1, 0, 3'b100, 3'b100, 4'b0000);
        step("f_own0",  1, 0, 3'b000, 3'b000, 4'b1000);
        step("f_idle2", 1, 0, 3'b000, 3'b000, 4'b0000);
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
